// File: rtl/hammer_mem_responder_pkg.sv
// Shared types and address-field helpers for the hammer memory responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hammer_mem_responder_pkg;

    // Responder FSM; encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Pull a bit field out of an address. Field widths up to 32 bits are
    // supported; the caller narrows the result to the real field width.
    function automatic logic [31:0] extract_field(input logic [63:0] addr,
                                                  input int unsigned pos,
                                                  input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return 32'((addr >> pos) & mask);
    endfunction

    function automatic logic [31:0] addr_row(input logic [63:0] addr,
                                             input int unsigned row_pos,
                                             input int unsigned row_width);
        return extract_field(addr, row_pos, row_width);
    endfunction

    function automatic logic [31:0] addr_col(input logic [63:0] addr,
                                             input int unsigned col_pos,
                                             input int unsigned col_width);
        return extract_field(addr, col_pos, col_width);
    endfunction

endpackage

// File: rtl/hammer_mem_responder_ram.sv
// Word storage for the responder: single port, synchronous read, write enable.
// Latency: read data is registered, valid one cycle after the address.
// Backpressure: none; accepts an access every cycle. No reset on contents.
//
// Ports: clk_i clock; we_i write enable; addr_i word index; wdata_i write
// word; rdata_o registered read word (old contents on a same-address write).
module responder_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/hammer_mem_responder.sv
// Memory responder that models row-hammer: neighbour activations of a victim row flip read data.
// Latency: READ_LATENCY / WRITE_LATENCY BUSY cycles after sampling, then one RESP cycle.
// Backpressure: wait_request is high except in RESP; the initiator holds its command until then.
//
// Ports: clk, reset (async, active-low); gen_address/gen_word/write/read form
// the command; wait_request low accepts it; read_data_valid strobes with
// pattern_rb; act_count, flipped and state expose the hammer tracker and FSM.
module hammer_mem_responder
    import hammer_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned ROW_WIDTH      = 12,
    parameter int unsigned ROW_POS        = 10,
    parameter int unsigned COL_WIDTH      = 10,
    parameter int unsigned COL_POS        = 1,
    parameter int unsigned READ_LATENCY   = 3,   // must be >= 1
    parameter int unsigned WRITE_LATENCY  = 1,   // must be >= 1
    parameter logic [31:0] FLIP_THRESHOLD = 32'd1000,
    parameter logic [WORD_WIDTH-1:0] FLIP_MASK = WORD_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] gen_address,
    input  logic [WORD_WIDTH-1:0] gen_word,
    input  logic                  write,
    input  logic                  read,
    output logic                  wait_request,
    output logic                  read_data_valid,
    output logic [WORD_WIDTH-1:0] pattern_rb,
    output logic [31:0]           act_count,
    output logic                  flipped,
    output logic [1:0]            state
);

    state_e                state_q;
    logic                  is_wr_q;
    logic [ROW_WIDTH-1:0]  row_q;
    logic [COL_WIDTH-1:0]  col_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic [31:0]           lat_cnt_q;
    logic                  wait_q;
    logic                  rdv_q;
    logic [WORD_WIDTH-1:0] pat_q;
    logic [31:0]           act_q;
    logic                  flipped_q;
    logic [ROW_WIDTH-1:0]  victim_q;
    logic [ROW_WIDTH-1:0]  last_q;

    logic [ROW_WIDTH-1:0]  cmd_row;
    logic [COL_WIDTH-1:0]  cmd_col;
    logic [COL_WIDTH-1:0]  ram_addr;
    logic                  ram_we;
    logic [WORD_WIDTH-1:0] ram_rdata;
    logic [WORD_WIDTH-1:0] rd_word;
    logic [ROW_WIDTH-1:0]  victim_up;
    logic [ROW_WIDTH-1:0]  victim_dn;
    logic                  is_act;

    assign cmd_row = ROW_WIDTH'(addr_row(64'(gen_address), ROW_POS, ROW_WIDTH));
    assign cmd_col = COL_WIDTH'(addr_col(64'(gen_address), COL_POS, COL_WIDTH));

    // The RAM is addressed from the live command while idle, so the stored
    // word is already on ram_rdata during the first BUSY cycle. This lets a
    // BUSY of one cycle still deliver data at the start of RESP.
    assign ram_addr = (state_q == ST_IDLE) ? cmd_col : col_q;
    assign ram_we   = (state_q == ST_RESP) && is_wr_q;

    responder_ram #(
        .ADDR_W (COL_WIDTH),
        .DATA_W (WORD_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (word_q),
        .rdata_o (ram_rdata)
    );

    // Only the victim row itself sees corrupted data once the flip has fired.
    assign rd_word = ram_rdata ^ ((flipped_q && (row_q == victim_q)) ? FLIP_MASK : '0);

    // Neighbours wrap modulo 2^ROW_WIDTH; re-reading the same row is not a
    // fresh activation.
    assign victim_up = victim_q + ROW_WIDTH'(1);
    assign victim_dn = victim_q - ROW_WIDTH'(1);
    assign is_act    = (row_q != last_q) && ((row_q == victim_up) || (row_q == victim_dn));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            word_q    <= '0;
            lat_cnt_q <= '0;
            wait_q    <= 1'b1;
            rdv_q     <= 1'b0;
            pat_q     <= '0;
            act_q     <= '0;
            flipped_q <= 1'b0;
            victim_q  <= '0;
            last_q    <= '0;
        end else begin
            // Sticky flip, set the cycle after the count reaches threshold.
            // A write RESP below overrides this and clears it.
            if (act_q >= FLIP_THRESHOLD) begin
                flipped_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (write || read) begin
                        is_wr_q   <= write;  // write wins when both are high
                        row_q     <= cmd_row;
                        col_q     <= cmd_col;
                        word_q    <= gen_word;
                        lat_cnt_q <= write ? 32'(WRITE_LATENCY - 1) : 32'(READ_LATENCY - 1);
                        state_q   <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (lat_cnt_q == 32'd0) begin
                        state_q <= ST_RESP;
                        wait_q  <= 1'b0;
                        rdv_q   <= !is_wr_q;
                        // Read word lands as RESP begins so it is valid
                        // alongside read_data_valid.
                        if (!is_wr_q) begin
                            pat_q <= rd_word;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 32'd1;
                    end
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                    wait_q  <= 1'b1;
                    rdv_q   <= 1'b0;
                    if (is_wr_q) begin
                        victim_q  <= row_q;
                        act_q     <= '0;
                        flipped_q <= 1'b0;
                    end else begin
                        last_q <= row_q;
                        if (is_act && (act_q != 32'hFFFF_FFFF)) begin
                            act_q <= act_q + 32'd1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    wait_q  <= 1'b1;
                    rdv_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wait_request    = wait_q;
    assign read_data_valid = rdv_q;
    assign pattern_rb      = pat_q;
    assign act_count       = act_q;
    assign flipped         = flipped_q;
    assign state           = state_q;

endmodule

// File: tb/tb_hammer_mem_responder.sv
// Self-checking bench for hammer_mem_responder: transaction-level model plus
// per-cycle compare process and hand-computed literal expectations.
// Runs directed vectors for latency, hammering, wrap-around, reset, and write/read collision.
module tb_hammer_mem_responder;

    localparam int          RLAT = 3;
    localparam int          WLAT = 1;
    localparam logic [31:0] THR  = 32'd4;
    localparam logic [63:0] MASK = 64'h1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] gen_address = '0;
    logic [63:0] gen_word = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        wait_request;
    logic        read_data_valid;
    logic [63:0] pattern_rb;
    logic [31:0] act_count;
    logic        flipped;
    logic [1:0]  state;

    hammer_mem_responder #(
        .READ_LATENCY   (RLAT),
        .WRITE_LATENCY  (WLAT),
        .FLIP_THRESHOLD (THR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .gen_address     (gen_address),
        .gen_word        (gen_word),
        .write           (write),
        .read            (read),
        .wait_request    (wait_request),
        .read_data_valid (read_data_valid),
        .pattern_rb      (pattern_rb),
        .act_count       (act_count),
        .flipped         (flipped),
        .state           (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: storage by column plus hammer tracker.
    logic [63:0] m_mem [int];
    logic [11:0] m_victim = '0;
    logic [11:0] m_last   = '0;
    logic [31:0] m_act    = '0;
    bit          m_flip   = 1'b0;

    // Expected per-cycle outputs, refreshed by the driver just after each edge.
    logic [1:0]  e_state = 2'd0;
    bit          e_wait  = 1'b1;
    bit          e_rdv   = 1'b0;
    logic [63:0] e_pat   = '0;
    bit          chk_en  = 1'b0;

    // Observations for the literal checks.
    int          issue_cyc     = 0;
    int          last_rdv_cyc  = -1;
    int          last_acc_cyc  = -1;
    int          rdv_count     = 0;
    logic [63:0] last_rd_pat   = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",           64'(state),           64'(e_state));
            chk("wait_request",    64'(wait_request),    64'(e_wait));
            chk("read_data_valid", 64'(read_data_valid), 64'(e_rdv));
            chk("pattern_rb",      pattern_rb,           e_pat);
            chk("act_count",       64'(act_count),       64'(m_act));
            chk("flipped",         64'(flipped),         64'(m_flip));
            if (!wait_request) last_acc_cyc = cyc;
            if (read_data_valid) begin
                last_rdv_cyc = cyc;
                last_rd_pat  = pattern_rb;
                rdv_count++;
            end
        end
    end

    function automatic logic [63:0] addr_of(input logic [11:0] row, input logic [9:0] col);
        return (64'(row) << 10) | (64'(col) << 1);
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] row, input logic [9:0] col);
        logic [63:0] d;
        d = m_mem.exists(int'(col)) ? m_mem[int'(col)] : 64'h0;
        if (m_flip && (row == m_victim)) d = d ^ MASK;
        return d;
    endfunction

    function automatic bit model_is_act(input logic [11:0] row);
        logic [11:0] up;
        logic [11:0] dn;
        up = m_victim + 12'd1;
        dn = m_victim - 12'd1;
        return (row != m_last) && ((row == up) || (row == dn));
    endfunction

    // Entered just after a clock edge with the DUT idle; returns the same way.
    task automatic do_cmd(input logic [63:0] addr, input logic [63:0] word,
                          input bit wr, input bit rd, input bit hold);
        int          lat;
        logic [11:0] row;
        logic [9:0]  col;
        lat = wr ? WLAT : RLAT;
        row = addr[21:10];
        col = addr[10:1];
        gen_address = addr;
        gen_word    = word;
        write       = wr;
        read        = rd;
        issue_cyc   = cyc;
        @(posedge clk); #1;
        e_state = 2'd1;
        if (!hold) begin write = 1'b0; read = 1'b0; end
        repeat (lat - 1) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        e_state = 2'd2;
        e_wait  = 1'b0;
        e_rdv   = !wr;
        if (!wr) e_pat = model_read(row, col);
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        e_state = 2'd0; e_wait = 1'b1; e_rdv = 1'b0;
        if (wr) begin
            m_mem[int'(col)] = word;
            m_victim = row;
            m_act = '0;
            m_flip = 1'b0;
        end else begin
            if (model_is_act(row) && (m_act != 32'hFFFF_FFFF)) m_act = m_act + 32'd1;
            m_last = row;
        end
        @(posedge clk); #1;
        if (m_act >= THR) m_flip = 1'b1;
    endtask

    task automatic model_reset();
        m_victim = '0; m_last = '0; m_act = '0; m_flip = 1'b0;
        e_state = 2'd0; e_wait = 1'b1; e_rdv = 1'b0; e_pat = '0;
    endtask

    int act_snap;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_wait",  64'(wait_request), 64'd1);
        chk("reset_rdv",   64'(read_data_valid), 64'd0);
        chk("reset_pat",   pattern_rb, 64'd0);
        chk("reset_act",   64'(act_count), 64'd0);
        chk("reset_flip",  64'(flipped), 64'd0);
        reset = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Basic write then read, with latency measured in cycles.
        do_cmd(addr_of(12'd0, 10'd5), 64'hA5A5, 1'b1, 1'b0, 1'b1);
        do_cmd(addr_of(12'd0, 10'd5), 64'h0,    1'b0, 1'b1, 1'b1);
        chk("lat_read_rdv_cycles", 64'(last_rdv_cyc - issue_cyc), 64'd4);
        chk("lat_wait_with_rdv",   64'(last_acc_cyc), 64'(last_rdv_cyc));
        chk("lit_read_a5a5",       last_rd_pat, 64'hA5A5);

        // Odd rows share address bit 10 with the column MSB, so they land on
        // column 512; give that column a known word first.
        do_cmd(addr_of(12'd1, 10'd0), 64'h5A00, 1'b1, 1'b0, 1'b1);
        do_cmd(addr_of(12'd8, 10'd0), 64'h0,    1'b1, 1'b0, 1'b1);
        do_cmd(addr_of(12'd9, 10'd0), 64'h0, 1'b0, 1'b1, 1'b0);  // drop command during BUSY
        do_cmd(addr_of(12'd7, 10'd0), 64'h0, 1'b0, 1'b1, 1'b1);
        do_cmd(addr_of(12'd9, 10'd0), 64'h0, 1'b0, 1'b1, 1'b1);
        do_cmd(addr_of(12'd7, 10'd0), 64'h0, 1'b0, 1'b1, 1'b1);
        do_cmd(addr_of(12'd8, 10'd0), 64'h0, 1'b0, 1'b1, 1'b1);
        chk("lit_hammer_act4",  64'(act_count), 64'd4);
        chk("lit_hammer_flip",  64'(flipped), 64'd1);
        chk("lit_victim_read1", last_rd_pat, 64'h1);

        // The first row-9 read follows a row-8 read and still counts;
        // further row-9 reads do not.
        do_cmd(addr_of(12'd9, 10'd0), 64'h0, 1'b0, 1'b1, 1'b1);
        act_snap = int'(act_count);
        chk("lit_first_row9_act5", 64'(act_snap), 64'd5);
        chk("lit_row9_unmasked", last_rd_pat, 64'h5A00);
        repeat (3) do_cmd(addr_of(12'd9, 10'd0), 64'h0, 1'b0, 1'b1, 1'b1);
        chk("lit_repeat_row9_act", 64'(act_count), 64'(act_snap));
        do_cmd(addr_of(12'd8, 10'd0), 64'h0, 1'b1, 1'b0, 1'b1);
        chk("lit_write_clr_act",  64'(act_count), 64'd0);
        chk("lit_write_clr_flip", 64'(flipped), 64'd0);

        // Victim row 0: neighbours 12'hFFF and 1 wrap around.
        do_cmd(addr_of(12'd0, 10'd0), 64'h77, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_cmd(addr_of((i % 2 == 0) ? 12'hFFF : 12'd1, 10'd0), 64'h0, 1'b0, 1'b1, 1'b1);
        end
        chk("lit_wrap_act4", 64'(act_count), 64'd4);
        do_cmd(addr_of(12'd0, 10'd5), 64'h0, 1'b0, 1'b1, 1'b1);
        chk("lit_victim0_flipped", last_rd_pat, 64'hA5A4);

        // Write and read together behave as a write.
        act_snap = rdv_count;
        do_cmd(addr_of(12'd0, 10'd7), 64'h3C, 1'b1, 1'b1, 1'b1);
        chk("lit_both_no_rdv", 64'(rdv_count), 64'(act_snap));
        do_cmd(addr_of(12'd0, 10'd7), 64'h0, 1'b0, 1'b1, 1'b1);
        chk("lit_both_stored", last_rd_pat, 64'h3C);

        // Reset in the BUSY cycle of a write discards it.
        do_cmd(addr_of(12'd0, 10'd3), 64'h1111, 1'b1, 1'b0, 1'b1);
        gen_address = addr_of(12'd0, 10'd3);
        gen_word    = 64'h2222;
        write       = 1'b1;
        @(posedge clk); #1;
        e_state = 2'd1;
        @(negedge clk); #1;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_async_state", 64'(state), 64'd0);
        chk("rst_async_wait",  64'(wait_request), 64'd1);
        chk("rst_async_act",   64'(act_count), 64'd0);
        @(posedge clk); #1;
        write = 1'b0;
        chk("rst_next_state", 64'(state), 64'd0);
        chk("rst_next_wait",  64'(wait_request), 64'd1);
        model_reset();
        reset  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        do_cmd(addr_of(12'd0, 10'd3), 64'h0, 1'b0, 1'b1, 1'b1);
        chk("lit_rst_keeps_old", last_rd_pat, 64'h1111);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
